// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants and FSM state encoding.
package fetch_unit_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] BOOT_ADDR = 32'h0000_1000;
    localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched instruction and its PC.
// Ports: load captures load_instr/load_pc; unload or clear empties the entry;
//        valid/instr/pc present the held word.
module fetch_skid_buffer
    import fetch_unit_pkg::*;
#(
    parameter int unsigned W = WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  logic [W-1:0] load_instr,
    input  logic [W-1:0] load_pc,
    output logic         valid,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc
);

    // Emptying wins over a same-cycle load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear || unload) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, icache request handshake and F/D pipeline register.
// Ports: clk/rst; increase_pc, stall_f_registers from the stall unit;
//        branch_taken/branch_target redirect; icache_op_done/icache_data
//        response; icache_req/icache_addr request; fd_valid/fd_instruction/
//        fd_pc F/D register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned            WORD_WIDTH_P = WORD_WIDTH,
    parameter logic [WORD_WIDTH_P-1:0] BOOT_ADDR_P = BOOT_ADDR,
    parameter logic [WORD_WIDTH_P-1:0] NOP_INSTR_P = NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    increase_pc,
    input  logic                    stall_f_registers,
    input  logic                    branch_taken,
    input  logic [WORD_WIDTH_P-1:0] branch_target,
    input  logic                    icache_op_done,
    input  logic [WORD_WIDTH_P-1:0] icache_data,
    output logic                    icache_req,
    output logic [WORD_WIDTH_P-1:0] icache_addr,
    output logic                    fd_valid,
    output logic [WORD_WIDTH_P-1:0] fd_instruction,
    output logic [WORD_WIDTH_P-1:0] fd_pc
);

    localparam logic [WORD_WIDTH_P-1:0] PC_STEP    = WORD_WIDTH_P'(4);
    localparam logic [WORD_WIDTH_P-1:0] ALIGN_MASK = ~WORD_WIDTH_P'(3);

    fetch_state_e            state, state_n;
    logic [WORD_WIDTH_P-1:0] pc, pc_n, pc_adv;
    logic                    req_n, fd_valid_n;
    logic [WORD_WIDTH_P-1:0] addr_n, fd_instr_n, fd_pc_n;
    logic                    skid_load, skid_unload, skid_clear, skid_valid;
    logic [WORD_WIDTH_P-1:0] skid_instr, skid_pc;

    fetch_skid_buffer #(.W(WORD_WIDTH_P)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_instr (icache_data),
        .load_pc    (pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // State and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_REQ;
            pc             <= BOOT_ADDR_P;
            icache_req     <= 1'b0;
            icache_addr    <= BOOT_ADDR_P;
            fd_valid       <= 1'b0;
            fd_instruction <= NOP_INSTR_P;
            fd_pc          <= '0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            icache_req     <= req_n;
            icache_addr    <= addr_n;
            fd_valid       <= fd_valid_n;
            fd_instruction <= fd_instr_n;
            fd_pc          <= fd_pc_n;
        end
    end

    // Next-state, PC, request and F/D register update.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_n       = icache_req;
        addr_n      = icache_addr;
        fd_valid_n  = fd_valid;
        fd_instr_n  = fd_instruction;
        fd_pc_n     = fd_pc;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        pc_adv      = increase_pc ? pc + PC_STEP : pc;

        // An unstalled F/D register becomes a bubble unless refilled below.
        if (!stall_f_registers) begin
            fd_valid_n = 1'b0;
            fd_instr_n = NOP_INSTR_P;
        end

        if (branch_taken) begin
            pc_n       = branch_target & ALIGN_MASK;
            fd_valid_n = 1'b0;
            fd_instr_n = NOP_INSTR_P;
            skid_clear = 1'b1;
            // An in-flight request cannot be aborted; wait it out and drop it.
            if ((state == S_WAIT || state == S_DRAIN) && !icache_op_done) begin
                state_n = S_DRAIN;
            end else begin
                state_n = S_REQ;
                req_n   = 1'b0;
            end
        end else begin
            unique case (state)
                S_REQ: begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (icache_op_done) begin
                        req_n = 1'b0;
                        if (!stall_f_registers) begin
                            fd_valid_n = 1'b1;
                            fd_instr_n = icache_data;
                            fd_pc_n    = pc;
                            pc_n       = pc_adv;
                            state_n    = S_REQ;
                        end else begin
                            skid_load = 1'b1;
                            state_n   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_f_registers) begin
                        fd_valid_n  = skid_valid;
                        fd_instr_n  = skid_instr;
                        fd_pc_n     = skid_pc;
                        skid_unload = 1'b1;
                        pc_n        = pc_adv;
                        state_n     = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (icache_op_done) begin
                        req_n   = 1'b0;
                        state_n = S_REQ;
                    end
                end
                default: state_n = S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] BOOT = 32'h0000_1000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        increase_pc, stall_f_registers, branch_taken, icache_op_done;
    logic [31:0] branch_target, icache_data;
    logic        icache_req, fd_valid;
    logic [31:0] icache_addr, fd_instruction, fd_pc;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: outstanding request, drop flag, held word.
    logic [31:0] m_pc, m_addr, m_skid_instr, m_skid_pc, m_fd_instr, m_fd_pc;
    logic        m_req, m_drop, m_skid_v, m_fd_v;

    fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .increase_pc       (increase_pc),
        .stall_f_registers (stall_f_registers),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .icache_op_done    (icache_op_done),
        .icache_data       (icache_data),
        .icache_req        (icache_req),
        .icache_addr       (icache_addr),
        .fd_valid          (fd_valid),
        .fd_instruction    (fd_instruction),
        .fd_pc             (fd_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = BOOT; m_addr = BOOT; m_req = 1'b0; m_drop = 1'b0;
        m_skid_v = 1'b0; m_skid_instr = '0; m_skid_pc = '0;
        m_fd_v = 1'b0; m_fd_instr = NOP; m_fd_pc = '0;
    endtask

    // Deliver the fetched word at address a into the pipeline and move on.
    task automatic model_deliver(input logic [31:0] instr, input logic [31:0] a);
        m_fd_v = 1'b1; m_fd_instr = instr; m_fd_pc = a;
        if (increase_pc) m_pc = a + 32'd4;
    endtask

    task automatic model_edge();
        if (!stall_f_registers) begin
            m_fd_v = 1'b0; m_fd_instr = NOP;
        end
        if (branch_taken) begin
            m_pc = {branch_target[31:2], 2'b00};
            m_fd_v = 1'b0; m_fd_instr = NOP; m_skid_v = 1'b0;
            if (m_req && !icache_op_done) m_drop = 1'b1;
            else begin m_req = 1'b0; m_drop = 1'b0; end
        end else if (m_req) begin
            if (icache_op_done) begin
                m_req = 1'b0;
                if (m_drop) m_drop = 1'b0;
                else if (!stall_f_registers) model_deliver(icache_data, m_addr);
                else begin
                    m_skid_v = 1'b1; m_skid_instr = icache_data; m_skid_pc = m_addr;
                end
            end
        end else if (m_skid_v) begin
            if (!stall_f_registers) begin
                m_skid_v = 1'b0;
                model_deliver(m_skid_instr, m_skid_pc);
            end
        end else begin
            m_req = 1'b1; m_addr = m_pc;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},   {31'd0, icache_req}, {31'd0, m_req});
        chk({tag, ".addr"},  icache_addr, m_addr);
        chk({tag, ".valid"}, {31'd0, fd_valid}, {31'd0, m_fd_v});
        chk({tag, ".instr"}, fd_instruction, m_fd_instr);
        chk({tag, ".fdpc"},  fd_pc, m_fd_pc);
    endtask

    // One clock: model follows the edge, outputs checked 1ns later,
    // returns at the negedge where the next inputs are driven.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1 check_all(tag);
        @(negedge clk);
    endtask

    task automatic drive(input logic st, input logic inc, input logic br,
                         input logic [31:0] tgt, input logic done, input logic [31:0] data);
        stall_f_registers = st; increase_pc = inc; branch_taken = br;
        branch_target = tgt; icache_op_done = done; icache_data = data;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        tick("issue0");
        tick("wait0");

        // 1: async reset mid-wait
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("t1_rst");
        chk("t1_req_low", {31'd0, icache_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick("t1_issue");
        chk("t1_addr", icache_addr, BOOT);
        chk("t1_req", {31'd0, icache_req}, 32'd1);

        // 2: plain completion
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h0050_0093);
        tick("t2_done");
        chk("t2_instr", fd_instruction, 32'h0050_0093);
        chk("t2_fdpc", fd_pc, BOOT);
        chk("t2_valid", {31'd0, fd_valid}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        tick("t2_issue");
        chk("t2_next_addr", icache_addr, 32'h0000_1004);

        // 3: completion under stall, held 3 cycles
        tick("t3_wait");
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h00A0_0113);
        tick("t3_hold0");
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        tick("t3_hold1");
        tick("t3_hold2");
        chk("t3_held_valid", {31'd0, fd_valid}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        tick("t3_release");
        chk("t3_instr", fd_instruction, 32'h00A0_0113);
        chk("t3_fdpc", fd_pc, 32'h0000_1004);
        tick("t3_issue");
        chk("t3_next_addr", icache_addr, 32'h0000_1008);

        // 4: branch while waiting, response dropped
        drive(1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b0, '0);
        tick("t4_branch");
        chk("t4_req_held", {31'd0, icache_req}, 32'd1);
        chk("t4_addr_held", icache_addr, 32'h0000_1008);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
        tick("t4_drain");
        chk("t4_dropped", {31'd0, fd_valid}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        tick("t4_issue");
        chk("t4_next_addr", icache_addr, 32'h0000_2000);

        // 5: branch coincident with completion
        drive(1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b1, 32'h1234_5678);
        tick("t5_branch");
        chk("t5_dropped", {31'd0, fd_valid}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        tick("t5_issue");
        chk("t5_next_addr", icache_addr, 32'h0000_2000);

        // 6: wrap at top of address space (target low bits masked)
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0);
        tick("t6_branch");
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        tick("t6_issue");
        chk("t6_top_addr", icache_addr, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h0000_0093);
        tick("t6_done");
        chk("t6_fdpc", fd_pc, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        tick("t6_issue_wrap");
        chk("t6_wrap_addr", icache_addr, 32'h0000_0000);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0113);
        tick("t6_done_noinc");
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        tick("t6_refetch");
        chk("t6_refetch_addr", icache_addr, 32'h0000_0000);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), $urandom(),
                  (m_req && ($urandom_range(0, 2) == 0)), $urandom());
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
